life_engine: RTL

//  Parametrised, self-sequencing Conway's Game of Life engine for an ROWS x COLS grid.

---
 rtl/life_if.sv | 26 ++
 rtl/life_engine.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/life_if.sv
// Board bus for life_engine: loader/UI controls in, grid and status out.
interface life_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
);
    logic                   load;
    logic [ROWS*COLS-1:0]   init_state;
    logic                   run;
    logic                   step;
    logic [ROWS*COLS-1:0]   grid;
    logic [GEN_W-1:0]       gen_count;
    logic                   busy;
    logic                   stable;
    logic                   extinct;

    modport master (
        output load, init_state, run, step,
        input  grid, gen_count, busy, stable, extinct
    );

    modport slave (
        input  load, init_state, run, step,
        output grid, gen_count, busy, stable, extinct
    );
endinterface

// File: rtl/life_engine.sv
// Conway's Game of Life engine (B3/S23) over a ROWS x COLS register grid.
// Generations are applied on a manual step while idle or every PERIOD cycles
// while running; halts itself when a generation is stable or extinct.
// Optional feature macro: LIFE_TORUS_EN selects toroidal wrap at the edges,
// otherwise cells outside the grid read as dead.
module life_engine #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int PERIOD = 4,
    parameter int GEN_W  = 16
) (
    input  logic  clk,
    input  logic  reset,
    life_if.slave bus
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int DIV_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CELLS-1:0]     grid_q, next_grid;
    logic [GEN_W-1:0]     gen_q;
    logic                 stable_q, extinct_q;
    logic                 apply_gen;
    logic                 next_same, next_dead;

    logic [3:0]           cnt;
    logic                 alive;
    logic                 valid;
    int                   rr, cc;

    // Combinational B3/S23 successor of the whole grid
    always_comb begin
        next_grid = '0;
        cnt       = '0;
        alive     = 1'b0;
        valid     = 1'b0;
        rr        = 0;
        cc        = 0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                cnt = '0;
                for (int unsigned dr = 0; dr < 3; dr++) begin
                    for (int unsigned dc = 0; dc < 3; dc++) begin
                        rr = int'(r) + int'(dr) - 1;
                        cc = int'(c) + int'(dc) - 1;
`ifdef LIFE_TORUS_EN
                        if (rr < 0) rr = ROWS - 1;
                        else if (rr >= ROWS) rr = 0;
                        if (cc < 0) cc = COLS - 1;
                        else if (cc >= COLS) cc = 0;
                        valid = 1'b1;
`else
                        valid = (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
`endif
                        if (valid && !(dr == 1 && dc == 1))
                            cnt = cnt + {3'b000, grid_q[IDX_W'(rr * COLS + cc)]};
                    end
                end
                alive = grid_q[IDX_W'(int'(r) * COLS + int'(c))];
                next_grid[IDX_W'(int'(r) * COLS + int'(c))] =
                    (cnt == 4'd3) || (alive && cnt == 4'd2);
            end
        end
    end

    assign next_same = (next_grid == grid_q);
    assign next_dead = (next_grid == '0);

    // Next-state and generation strobe for the IDLE/RUN/HALT sequencer
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        apply_gen = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = RUN;
                    div_d   = '0;
                end else if (bus.step) begin
                    apply_gen = 1'b1;
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_W'(PERIOD - 1)) begin
                    apply_gen = 1'b1;
                    div_d     = '0;
                    if (next_same || next_dead) state_d = HALT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HALT: begin
                if (!bus.run) begin
                    state_d = IDLE;
                    div_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
            end
        endcase
    end

    // State, grid and status registers; load overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            grid_q    <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else if (bus.load) begin
            state_q   <= IDLE;
            div_q     <= '0;
            grid_q    <= bus.init_state;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            if (apply_gen) begin
                grid_q    <= next_grid;
                if (gen_q != '1) gen_q <= gen_q + 1'b1;
                stable_q  <= next_same;
                extinct_q <= next_dead;
            end
        end
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct_q;
endmodule
